// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch PC sequencing with stall, eret/jump/branch redirects and a single-level interrupt FSM
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] INT_VECTOR = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PC_Stall,
   input  logic        Branch_Taken,
   input  logic [31:0] Branch_Target,
   input  logic        Jump,
   input  logic [31:0] Jump_Target,
   input  logic        Eret,
   input  logic        Int_Req,
   output logic [31:0] PC,
   output logic [31:0] PCplus4,
   output logic        IF_ID_Flush,
   output logic [31:0] EPC,
   output logic        Int_Ack,
   output logic        In_ISR
);
   typedef enum logic {NORMAL, ISR} state_t;
   state_t state;
   logic pending;
   logic eret_ok;
   logic take_int;
   assign eret_ok     = !PC_Stall && Eret && state == ISR;
   assign take_int    = !PC_Stall && !Jump && !Branch_Taken && state == NORMAL && pending;
   assign IF_ID_Flush = reset && !PC_Stall && (eret_ok || Jump || Branch_Taken || take_int);
   assign Int_Ack     = reset && take_int;
   assign PCplus4     = PC + 32'd4;
   assign In_ISR      = state == ISR;
   always_ff @(posedge clk) begin
      if (!reset) begin
         PC      <= RESET_PC;
         EPC     <= '0;
         pending <= 1'b0;
         state   <= NORMAL;
      end else begin
         pending <= Int_Req || (pending && !take_int);
         if (!PC_Stall) begin
            if (eret_ok) begin
               PC    <= {EPC[31:2], 2'b00};
               state <= NORMAL;
            end else if (Jump)
               PC <= {Jump_Target[31:2], 2'b00};
            else if (Branch_Taken)
               PC <= {Branch_Target[31:2], 2'b00};
            else if (take_int) begin
               EPC   <= PC;
               PC    <= INT_VECTOR;
               state <= ISR;
            end else
               PC <= PCplus4;
         end
      end
   end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus randomized traffic checked against a behavioural model
module tb_pc_fetch_unit;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic PC_Stall = 1'b0, Branch_Taken = 1'b0, Jump = 1'b0, Eret = 1'b0, Int_Req = 1'b0;
   logic [31:0] Branch_Target = '0, Jump_Target = '0;
   logic [31:0] PC, PCplus4, EPC;
   logic IF_ID_Flush, Int_Ack, In_ISR;
   int checks = 0;
   int errors = 0;
   logic [31:0] m_pc = 32'h0, m_epc = 32'h0;
   logic m_isr = 1'b0, m_pend = 1'b0;
   logic s_fl, s_ack;

   pc_fetch_unit dut (
      .clk(clk), .reset(reset), .PC_Stall(PC_Stall),
      .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
      .Jump(Jump), .Jump_Target(Jump_Target), .Eret(Eret), .Int_Req(Int_Req),
      .PC(PC), .PCplus4(PCplus4), .IF_ID_Flush(IF_ID_Flush), .EPC(EPC),
      .Int_Ack(Int_Ack), .In_ISR(In_ISR)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   // Classify the cycle by the priority rules, check outputs mid-cycle, then advance the model at the edge.
   task automatic cycle();
      string kind;
      @(negedge clk);
      if (!reset) kind = "rst";
      else if (PC_Stall) kind = "stall";
      else if (Eret && m_isr) kind = "eret";
      else if (Jump) kind = "jump";
      else if (Branch_Taken) kind = "branch";
      else if (!m_isr && m_pend) kind = "int";
      else kind = "seq";
      s_fl  = IF_ID_Flush;
      s_ack = Int_Ack;
      chk("pc", PC, m_pc);
      chk("pcplus4", PCplus4, m_pc + 32'd4);
      chk("epc", EPC, m_epc);
      chk("in_isr", {31'b0, In_ISR}, {31'b0, m_isr});
      chk("flush", {31'b0, IF_ID_Flush},
          {31'b0, kind == "eret" || kind == "jump" || kind == "branch" || kind == "int"});
      chk("int_ack", {31'b0, Int_Ack}, {31'b0, kind == "int"});
      @(posedge clk);
      if (kind == "rst") begin
         m_pc = 32'h0; m_epc = 32'h0; m_isr = 1'b0; m_pend = 1'b0;
      end else begin
         if (kind == "eret") begin m_pc = m_epc & ~32'd3; m_isr = 1'b0; end
         else if (kind == "jump") m_pc = Jump_Target & ~32'd3;
         else if (kind == "branch") m_pc = Branch_Target & ~32'd3;
         else if (kind == "int") begin m_epc = m_pc; m_pc = 32'h100; m_isr = 1'b1; end
         else if (kind == "seq") m_pc = m_pc + 32'd4;
         m_pend = Int_Req || (m_pend && kind != "int");
      end
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      cycle();
      chk("rst_flush", {31'b0, s_fl}, 32'h0);
      reset = 1'b1;
      chk("idle_pc0", PC, 32'h0);
      cycle(); chk("idle_pc1", PC, 32'h4);
      cycle(); chk("idle_pc2", PC, 32'h8);
      chk("idle_flush", {31'b0, s_fl}, 32'h0);
      cycle(); chk("idle_pc3", PC, 32'hC);
      Int_Req = 1'b1; cycle(); Int_Req = 1'b0;
      chk("int_pc", PC, 32'h10);
      cycle();
      chk("int_ack", {31'b0, s_ack}, 32'h1);
      chk("int_flush", {31'b0, s_fl}, 32'h1);
      chk("int_epc", EPC, 32'h10);
      chk("int_vec", PC, 32'h100);
      chk("int_isr", {31'b0, In_ISR}, 32'h1);
      Eret = 1'b1; cycle(); Eret = 1'b0;
      chk("eret_pc", PC, 32'h10);
      Int_Req = 1'b1; cycle(); Int_Req = 1'b0;
      Jump = 1'b1; Jump_Target = 32'h40; cycle(); Jump = 1'b0;
      chk("jmp_pc", PC, 32'h40);
      chk("jmp_noack", {31'b0, s_ack}, 32'h0);
      cycle();
      chk("jmp_defer_ack", {31'b0, s_ack}, 32'h1);
      chk("jmp_defer_epc", EPC, 32'h40);
      Int_Req = 1'b1; cycle(); Int_Req = 1'b0;
      Eret = 1'b1; cycle(); Eret = 1'b0;
      chk("isr_eret_pc", PC, 32'h40);
      chk("isr_eret_state", {31'b0, In_ISR}, 32'h0);
      chk("isr_eret_noack", {31'b0, s_ack}, 32'h0);
      cycle();
      chk("isr_int_ack", {31'b0, s_ack}, 32'h1);
      chk("isr_int_epc", EPC, 32'h40);
      Eret = 1'b1; cycle(); Eret = 1'b0;
      Int_Req = 1'b1; cycle(); Int_Req = 1'b0;
      PC_Stall = 1'b1; Branch_Taken = 1'b1; Branch_Target = 32'h80;
      for (int i = 0; i < 2; i++) begin
         cycle();
         chk("stall_pc", PC, 32'h44);
         chk("stall_flush", {31'b0, s_fl}, 32'h0);
         chk("stall_ack", {31'b0, s_ack}, 32'h0);
      end
      PC_Stall = 1'b0; cycle(); Branch_Taken = 1'b0;
      chk("stall_br_pc", PC, 32'h80);
      chk("stall_br_noack", {31'b0, s_ack}, 32'h0);
      cycle();
      chk("stall_int_ack", {31'b0, s_ack}, 32'h1);
      chk("stall_int_epc", EPC, 32'h80);
      Eret = 1'b1; cycle(); Eret = 1'b0;
      Branch_Taken = 1'b1; Branch_Target = 32'hFFFF_FFFE; cycle(); Branch_Taken = 1'b0;
      chk("wrap_pc", PC, 32'hFFFF_FFFC);
      chk("wrap_pcplus4", PCplus4, 32'h0);
      cycle(); chk("wrap_pc0", PC, 32'h0);
      Int_Req = 1'b1; cycle(); Int_Req = 1'b0;
      cycle(); chk("pre_rst_isr", {31'b0, In_ISR}, 32'h1);
      reset = 1'b0; cycle(); reset = 1'b1;
      chk("rst_isr_pc", PC, 32'h0);
      chk("rst_isr_state", {31'b0, In_ISR}, 32'h0);
      chk("rst_isr_epc", EPC, 32'h0);
      chk("rst_isr_flush", {31'b0, s_fl}, 32'h0);
      for (int i = 0; i < 3000; i++) begin
         reset         = $urandom_range(99) != 0;
         PC_Stall      = $urandom_range(4) == 0;
         Eret          = $urandom_range(5) == 0;
         Jump          = $urandom_range(7) == 0;
         Branch_Taken  = $urandom_range(5) == 0;
         Int_Req       = $urandom_range(9) == 0;
         Jump_Target   = $urandom;
         Branch_Target = $urandom;
         cycle();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the fetch address after reset.
REQ-002 The block SHALL have parameter INT_VECTOR, default 32'h0000_0100, which is the interrupt service entry address.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port PC_Stall, input, 1 bit: hazard-unit request to hold the PC.
REQ-006 The block SHALL have port Branch_Taken, input, 1 bit, and port Branch_Target, input, 32 bits: taken branch resolved in ID.
REQ-007 The block SHALL have port Jump, input, 1 bit, and port Jump_Target, input, 32 bits: jump decoded in ID.
REQ-008 The block SHALL have port Eret, input, 1 bit: exception-return decoded in ID.
REQ-009 The block SHALL have port Int_Req, input, 1 bit: level-sensitive external interrupt request.
REQ-010 The block SHALL have port PC, output, 32 bits: the current fetch address.
REQ-011 The block SHALL have port PCplus4, output, 32 bits: PC+4, which feeds the IF/ID register.
REQ-012 The block SHALL have port IF_ID_Flush, output, 1 bit: discards the instruction fetched this cycle.
REQ-013 The block SHALL have port EPC, output, 32 bits: the saved return address.
REQ-014 The block SHALL have port Int_Ack, output, 1 bit: pulses in the cycle an interrupt is taken.
REQ-015 The block SHALL have port In_ISR, output, 1 bit: high while in state ISR.

Function
REQ-016 The FSM SHALL have two states, NORMAL and ISR, and In_ISR SHALL equal (state==ISR).
REQ-017 The pending flag SHALL be set on any edge where Int_Req=1, in either state, and cleared only when an interrupt is taken or on reset.
REQ-018 PCplus4 SHALL be PC+4, computed modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-019 Branch_Target, Jump_Target and EPC SHALL have bits [1:0] forced to 0 when loaded into PC.
REQ-020 The next PC SHALL be selected by strict priority, in this order:
 (a) PC_Stall=1: PC holds; no flush, no interrupt, no Eret accepted; pending is kept.
 (b) Eret=1 and state ISR: PC<=EPC, state<=NORMAL.
 (c) Jump=1: PC<=Jump_Target.
 (d) Branch_Taken=1: PC<=Branch_Target.
 (e) state NORMAL and pending=1: interrupt taken; EPC<=PC, PC<=INT_VECTOR, state<=ISR, pending cleared.
 (f) Otherwise: PC<=PC+4.
REQ-021 IF_ID_Flush SHALL be combinational and high exactly in cycles where case (b), (c), (d) or (e) is accepted.
REQ-022 Int_Ack SHALL be combinational and high only in case (e), for exactly one cycle per interrupt taken.
REQ-023 An interrupt blocked by a redirect SHALL be deferred and taken in the next eligible cycle, with EPC equal to the redirect target.
REQ-024 Int_Req asserted during ISR SHALL be latched into pending and taken no earlier than the cycle after the accepted Eret, with EPC equal to the restored PC.
REQ-025 Eret asserted in state NORMAL SHALL be ignored, and evaluation SHALL fall through to (c)–(f).
REQ-026 EPC SHALL change only in case (e) or on reset.
REQ-027 The latency from redirect acceptance to PC showing the target SHALL be one cycle.

Reset
REQ-028 When reset=0 at a rising edge, the block SHALL set PC=RESET_PC, PCplus4=RESET_PC+4, EPC=0, pending=0 and state=NORMAL, overriding all other inputs.
REQ-029 During reset, IF_ID_Flush and Int_Ack SHALL be 0.
REQ-030 Reset asserted during ISR or with an interrupt pending SHALL return the block to NORMAL and discard the pending request.

Verification
REQ-031 The bench SHALL cover reset release followed by 3 idle cycles: PC must read 0x0, 0x4, 0x8, 0xC; Flush=0.
REQ-032 The bench SHALL cover Int_Req=1 for one cycle at PC=0x10 with no redirect: pending is set; next cycle Int_Ack=1, Flush=1, then EPC=0x10, PC=0x100, In_ISR=1.
REQ-033 The bench SHALL cover pending=1 and Jump=1 to 0x40 in the same cycle: PC=0x40 and Int_Ack=0; next cycle Int_Ack=1, then EPC=0x40.
REQ-034 The bench SHALL cover Eret in ISR with EPC=0x40 while Int_Req=1 is also latched: PC=0x40 and state NORMAL; next cycle the interrupt is taken with EPC=0x40.
REQ-035 The bench SHALL cover PC_Stall=1 for 2 cycles concurrent with Branch_Taken and pending: PC holds, Flush=0, Int_Ack=0; after release the branch is taken first.
REQ-036 The bench SHALL cover Branch_Target=32'hFFFF_FFFE: PC=0xFFFF_FFFC, then 0x0; and reset=0 mid-ISR must give PC=0x0, In_ISR=0, EPC=0.
